// File: rtl/router_pkt_tx.sv
// router_pkt_tx -- packet transmitter feeding a router port.
//
// Payload bytes are written into a FIFO with pld_wr/pld_data. A start request
// that passes its checks sends one packet on data_out: a header byte
// {payload_len, dest_addr}, then payload_len bytes popped from the FIFO, then
// a parity byte that is the XOR of the header and every payload byte. The
// receiving router stalls the transfer with busy; a byte on data_out is only
// consumed at an edge where busy is low.
//
// Ports
//   clk           clock, rising edge
//   resetn        synchronous active-low reset
//   pld_wr        payload write strobe (dropped while pld_full)
//   pld_data      payload byte
//   start         request to send one packet (acted on in IDLE only)
//   dest_addr     destination port 0..2, sampled at accept
//   payload_len   payload byte count 1..63, sampled at accept
//   busy          router stall; holds the current byte
//   data_out      packet byte to the router
//   packet_valid  high for header and payload bytes
//   tx_busy       high while a packet is in flight
//   tx_done       one-cycle pulse after the parity byte is consumed
//   err           one-cycle pulse after a rejected start
//   pld_count     bytes held in the payload FIFO
//   pld_full      payload FIFO full

module router_pkt_tx #(
  parameter int FIFO_DEPTH = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pld_wr,
  input  logic [7:0] pld_data,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       packet_valid,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       err,
  output logic [6:0] pld_count,
  output logic       pld_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, PARITY} state_t;

  state_t        state, state_nx;
  logic [7:0]    parity, parity_nx;
  logic [5:0]    remaining, remaining_nx;
  logic [7:0]    data_nx;
  logic          valid_nx, done_nx, err_nx;
  logic          pop;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          full, wr_en, start_ok;
  logic [7:0]    head, header;

  assign full      = (cnt == CW'(FIFO_DEPTH));
  assign wr_en     = pld_wr && !full;
  assign head      = mem[rd_ptr];
  assign header    = {payload_len, dest_addr};
  // Occupancy is checked before this edge's write, so a byte arriving with
  // the start cannot make up a short payload.
  assign start_ok  = (dest_addr != 2'd3) && (payload_len != 6'd0) &&
                     (cnt >= CW'(payload_len));

  assign tx_busy   = (state != IDLE);
  assign pld_count = 7'(cnt);
  assign pld_full  = full;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned
    // and infers a latch.
    state_nx     = state;
    data_nx      = data_out;
    valid_nx     = packet_valid;
    parity_nx    = parity;
    remaining_nx = remaining;
    pop          = 1'b0;
    done_nx      = 1'b0;
    err_nx       = 1'b0;

    unique case (state)
      IDLE: begin
        // A start seen while the router is stalled is ignored silently.
        if (start && !busy) begin
          if (start_ok) begin
            data_nx      = header;
            valid_nx     = 1'b1;
            parity_nx    = header;
            remaining_nx = payload_len;
            state_nx     = SEND;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      SEND: begin
        if (!busy) begin
          if (remaining != 6'd0) begin
            data_nx      = head;
            pop          = 1'b1;
            parity_nx    = parity ^ head;
            remaining_nx = remaining - 6'd1;
          end else begin
            data_nx  = parity;
            valid_nx = 1'b0;
            state_nx = PARITY;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          data_nx  = 8'h00;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      data_out     <= 8'h00;
      packet_valid <= 1'b0;
      tx_done      <= 1'b0;
      err          <= 1'b0;
      parity       <= 8'h00;
      remaining    <= 6'd0;
    end else begin
      state        <= state_nx;
      data_out     <= data_nx;
      packet_valid <= valid_nx;
      tx_done      <= done_nx;
      err          <= err_nx;
      parity       <= parity_nx;
      remaining    <= remaining_nx;
    end
  end

  // ------------------------------------------------------- payload FIFO
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(wr_en) - CW'(pop);
    end
  end

  // NOTE: the storage array has no reset; emptying the FIFO only needs the
  // pointers and count cleared, and stale contents are never read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= pld_data;
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx. A transaction-level model keeps the
// payload FIFO as a byte queue and, at each accepted start, builds the whole
// packet (header, payload copy, XOR parity) as a queue of beats; every
// consumed edge advances one beat. Outputs are compared every cycle, #1 after
// the rising edge, plus literal checks for the directed scenarios.

module tb_router_pkt_tx;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pld_wr = 1'b0;
  logic [7:0] pld_data = 8'h00;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [5:0] payload_len = 6'd0;
  logic       busy = 1'b0;
  logic [7:0] data_out;
  logic       packet_valid, tx_busy, tx_done, err, pld_full;
  logic [6:0] pld_count;

  router_pkt_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .pld_wr(pld_wr), .pld_data(pld_data),
    .start(start), .dest_addr(dest_addr), .payload_len(payload_len),
    .busy(busy), .data_out(data_out), .packet_valid(packet_valid),
    .tx_busy(tx_busy), .tx_done(tx_done), .err(err),
    .pld_count(pld_count), .pld_full(pld_full)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  typedef struct {
    logic [7:0] b;
    bit         v;
    bit         pay;
  } beat_t;

  logic [7:0] m_fifo[$];
  beat_t      m_pkt[$];   // m_pkt[0] is the beat currently on data_out
  logic [7:0] m_data = 8'h00;
  bit         m_pv = 1'b0, m_done = 1'b0, m_err = 1'b0;
  bit         armed = 1'b0;

  function automatic void model_step();
    bit         was_full;
    logic [7:0] hdr, par;
    was_full = (m_fifo.size() >= DEPTH);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!resetn) begin
      m_fifo.delete();
      m_pkt.delete();
      m_data = 8'h00;
      m_pv   = 1'b0;
      return;
    end
    if (m_pkt.size() != 0) begin
      if (!busy) begin
        void'(m_pkt.pop_front());
        if (m_pkt.size() == 0) begin
          m_data = 8'h00;
          m_pv   = 1'b0;
          m_done = 1'b1;
        end else begin
          m_data = m_pkt[0].b;
          m_pv   = m_pkt[0].v;
          if (m_pkt[0].pay) void'(m_fifo.pop_front());
        end
      end
    end else if (start && !busy) begin
      if (dest_addr != 2'd3 && payload_len != 6'd0 && m_fifo.size() >= int'(payload_len)) begin
        hdr = {payload_len, dest_addr};
        par = hdr;
        m_pkt.push_back('{hdr, 1'b1, 1'b0});
        for (int i = 0; i < int'(payload_len); i++) begin
          m_pkt.push_back('{m_fifo[i], 1'b1, 1'b1});
          par ^= m_fifo[i];
        end
        m_pkt.push_back('{par, 1'b0, 1'b0});
        m_data = hdr;
        m_pv   = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (pld_wr && !was_full) m_fifo.push_back(pld_data);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    if (!resetn) armed = 1'b1;
    #1;
    if (armed) begin
      check("data_out",     data_out,     m_data);
      check("packet_valid", packet_valid, m_pv);
      check("tx_busy",      tx_busy,      m_pkt.size() != 0);
      check("tx_done",      tx_done,      m_done);
      check("err",          err,          m_err);
      check("pld_count",    pld_count,    m_fifo.size());
      check("pld_full",     pld_full,     m_fifo.size() == DEPTH);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    pld_wr = 1'b1;
    pld_data = d;
    tick();
    pld_wr = 1'b0;
  endtask

  task automatic send(input logic [1:0] a, input logic [5:0] l);
    start = 1'b1;
    dest_addr = a;
    payload_len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (tx_busy && k < 200) begin
      tick();
      k++;
    end
    check("idle_timeout", tx_busy, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  // ---------------------------------------------------------- stimulus
  logic [7:0] got[$];
  logic [7:0] exp_seq[5];
  int         n_run, n_idle;

  initial begin
    exp_seq = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};

    // Reset state
    tick();
    do_reset();
    check("rst_data",  data_out,     8'h00);
    check("rst_valid", packet_valid, 1'b0);
    check("rst_count", pld_count,    7'd0);

    // Basic packet, addr 1, len 3
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    send(2'd1, 6'd3);
    for (int k = 0; k < 10 && tx_busy; k++) begin
      got.push_back(data_out);
      tick();
    end
    check("basic_len", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) check("basic_byte", got[i], exp_seq[i]);
    check("basic_done",  tx_done,   1'b1);
    check("basic_count", pld_count, 7'd0);
    tick();

    // Same packet with a 3-cycle stall on B2
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    send(2'd1, 6'd3);
    check("stall_hdr", data_out, 8'h0D);
    tick(); check("stall_a1", data_out, 8'hA1);
    tick(); check("stall_b2", data_out, 8'hB2);
    busy = 1'b1;
    repeat (3) begin
      tick();
      check("stall_hold", data_out, 8'hB2);
    end
    busy = 1'b0;
    tick(); check("stall_c3", data_out, 8'hC3);
    tick(); check("stall_par", data_out, 8'hDD); check("stall_par_v", packet_valid, 1'b0);
    tick(); check("stall_done", tx_done, 1'b1);
    tick();

    // Rejected starts with 4 bytes buffered
    repeat (4) push_byte(8'($urandom));
    send(2'd3, 6'd2); check("rej_addr", err, 1'b1); check("rej_addr_busy", tx_busy, 1'b0);
    tick();           check("rej_pulse", err, 1'b0);
    send(2'd1, 6'd0); check("rej_len0", err, 1'b1);
    send(2'd1, 6'd5); check("rej_short", err, 1'b1); check("rej_count", pld_count, 7'd4);
    tick();
    send(2'd0, 6'd4);
    wait_idle();
    tick();

    // Fill past full, then write and pop on the same edge
    pld_wr = 1'b1;
    repeat (65) begin
      pld_data = 8'($urandom);
      tick();
    end
    pld_wr = 1'b0;
    check("full_flag",  pld_full,  1'b1);
    check("full_count", pld_count, 7'd64);
    send(2'd2, 6'd10);
    pld_wr = 1'b1;
    tick();                                  // pop while full: write dropped
    tick();                                  // pop plus write
    check("wr_pop_count", pld_count, 7'd63);
    pld_wr = 1'b0;
    wait_idle();
    do_reset();

    // Reset during the second payload byte
    repeat (5) push_byte(8'($urandom));
    send(2'd1, 6'd5);
    tick(); tick();
    resetn = 1'b0;
    pld_wr = 1'b1;
    tick();
    check("abort_data",  data_out,     8'h00);
    check("abort_valid", packet_valid, 1'b0);
    check("abort_count", pld_count,    7'd0);
    resetn = 1'b1;
    pld_wr = 1'b0;
    tick();
    check("abort_nodone", tx_done, 1'b0);
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    send(2'd1, 6'd3);
    wait_idle();
    tick();

    // Two 63-byte packets back to back with start held
    pld_wr = 1'b1;
    repeat (64) begin
      pld_data = 8'($urandom);
      tick();
    end
    start = 1'b1; dest_addr = 2'd2; payload_len = 6'd63;
    tick();
    n_run = 0;
    while (tx_busy && n_run < 200) begin
      pld_data = 8'($urandom);
      tick();
      n_run++;
    end
    check("b2b_run", n_run, 65);
    check("b2b_done", tx_done, 1'b1);
    n_idle = 0;
    while (!tx_busy && n_idle < 10) begin
      tick();
      n_idle++;
    end
    start = 1'b0;
    pld_wr = 1'b0;
    check("b2b_gap", n_idle, 1);
    check("b2b_hdr", data_out, 8'hFE);
    wait_idle();
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      resetn   = ($urandom_range(0, 299) != 0);
      pld_wr   = ($urandom_range(0, 2) != 0);
      pld_data = 8'($urandom);
      start    = ($urandom_range(0, 3) == 0);
      dest_addr = 2'($urandom_range(0, 3));
      payload_len = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                                : 6'($urandom_range(1, 12));
      busy     = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
